// File: rtl/xor_bist_ctrl.sv
// -----------------------------------------------------------------------------
// xor_bist_ctrl
//   Built-in self-test sequencer for an N-input XOR gate. A start pulse sweeps
//   every input vector 0 .. 2^N-1 onto the gate. Each vector is held for a
//   settle interval, then the gate output is compared with the parity of the
//   vector. Mismatches are counted and the first failing vector is captured.
//   A one-cycle done pulse ends a complete sweep, together with the pass flag.
//
// Parameters
//   N       number of gate inputs (>= 1)
//   SETTLE  wait cycles between driving a vector and sampling the output (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep; only honoured while idle
//   abort      in   cancel a sweep in progress
//   dut_in     out  [N-1:0] vector driven to the gate under test
//   dut_out    in   gate output
//   busy       out  high while a sweep is applying/settling/checking vectors
//   done       out  one-cycle pulse after the last vector of a full sweep
//   pass       out  sweep result, valid from done until the next start
//   err_count  out  [N:0] number of mismatching vectors
//   fail_vec   out  [N-1:0] first mismatching vector (valid if err_count != 0)
// -----------------------------------------------------------------------------
module xor_bist_ctrl #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] dut_in,
  input  logic         dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] fail_vec
);

  // Settle counter only needs to hold the value SETTLE.
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);
  localparam logic [N-1:0]  VEC_LAST    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state_q,   state_d;
  logic [N-1:0]  vec_q,     vec_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [N-1:0]  dut_in_q,  dut_in_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          pass_q,    pass_d;
  logic [N:0]    err_q,     err_d;
  logic [N-1:0]  fail_q,    fail_d;

  logic          mismatch;

  // Gate under test should produce the parity of the applied vector.
  assign mismatch = (dut_out != (^vec_q));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    dut_in_d = dut_in_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;

    unique case (state_q)
      S_IDLE: begin
        dut_in_d = '0;
        if (start) begin
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        dut_in_d = vec_q;
        cnt_d    = SETTLE_LOAD;
        state_d  = S_WAIT;
      end

      // Loaded with SETTLE, leaving on 1 gives exactly SETTLE wait cycles.
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_d = vec_q;
          end
        end
        // End detected before incrementing, so vec never wraps.
        if (vec_q == VEC_LAST) begin
          // Result is published together with done, using the final count.
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = S_APPLY;
        end
      end

      S_DONE: begin
        pass_d   = (err_q == '0);
        dut_in_d = '0;
        state_d  = S_IDLE;
      end

      default: begin
        dut_in_d = '0;
        state_d  = S_IDLE;
      end
    endcase

    // Abort overrides any update made by an active state this cycle; the
    // partial error count and first failing vector are kept.
    if (abort && (state_q inside {S_APPLY, S_WAIT, S_CHECK})) begin
      state_d  = S_IDLE;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      dut_in_d = '0;
      pass_d   = 1'b0;
      err_d    = err_q;
      fail_d   = fail_q;
    end

    // Status outputs are registered copies of the next state.
    busy_d = (state_d inside {S_APPLY, S_WAIT, S_CHECK});
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xor_bist_ctrl
//   Self-checking bench for xor_bist_ctrl (N=3, SETTLE=2). A behavioural gate
//   model (correct, stuck-0, inverted, or random per-vector faults) drives
//   dut_out. Expected sweep results are computed by enumerating all vectors
//   and pushed to a scoreboard; a monitor compares them when done pulses and
//   also checks the applied vector and busy against the cycle count since the
//   start edge.
// -----------------------------------------------------------------------------
module tb_xor_bist_ctrl;

  localparam int N     = 3;
  localparam int S     = 2;
  localparam int NV    = 1 << N;
  localparam int VL    = S + 2;
  localparam int TOTAL = NV * VL;

  typedef struct {
    int err;
    int fv;
    int pass;
    int done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] dut_in;
  logic         dut_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] fail_vec;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mode = 0;
  logic [NV-1:0] mask = '0;

  exp_t sb[$];
  bit   sweep_active = 1'b0;
  int   sweep_start = 0;

  xor_bist_ctrl #(.N(N), .SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model ----------------
  function automatic int parity(int v);
    int c = 0;
    for (int i = 0; i < N; i++) c += (v >> i) & 1;
    return c % 2;
  endfunction

  function automatic int gate(int v);
    case (mode)
      0:       return parity(v);
      1:       return 0;
      2:       return 1 - parity(v);
      default: return parity(v) ^ int'(mask[v]);
    endcase
  endfunction

  function automatic int count_errs(int lim);
    int c = 0;
    for (int v = 0; v < lim; v++) if (gate(v) != parity(v)) c++;
    return c;
  endfunction

  function automatic int first_fail(int lim);
    for (int v = 0; v < lim; v++) if (gate(v) != parity(v)) return v;
    return 0;
  endfunction

  always_comb dut_out = gate(int'(dut_in)) != 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int   k;
    exp_t e;
    if (rst_n) begin
      if (sweep_active) begin
        k = cyc - sweep_start;
        if (k >= 0) begin
          check("dut_in_seq", int'(dut_in), (k == 0) ? 0 : (k - 1) / VL);
          check("busy_seq", int'(busy), (k < TOTAL) ? 1 : 0);
          if (k >= TOTAL) sweep_active = 1'b0;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("err_count", int'(err_count), e.err);
          check("fail_vec", int'(fail_vec), e.fv);
          check("pass", int'(pass), e.pass);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_start(input int hold, input bit with_abort, input bit push,
                             output int e0);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    e0 = cyc + 1;
    if (push) begin
      e.err      = count_errs(NV);
      e.fv       = first_fail(NV);
      e.pass     = (e.err == 0) ? 1 : 0;
      e.done_cyc = e0 + TOTAL;
      sb.push_back(e);
    end
    sweep_start  = e0;
    sweep_active = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (hold - 1) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sweep();
    int t = 0;
    while (sweep_active && t < TOTAL + 20) begin
      @(negedge clk);
      t++;
    end
    check("sweep_timeout", int'(sweep_active), 0);
    sweep_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic full_sweep(input int hold, input bit with_abort);
    int e0;
    int res_pass;
    int res_err;
    issue_start(hold, with_abort, 1'b1, e0);
    wait_sweep();
    // Results must hold in IDLE until the next start.
    res_pass = count_errs(NV) == 0 ? 1 : 0;
    res_err  = count_errs(NV);
    check("pass_hold", int'(pass), res_pass);
    check("err_hold", int'(err_count), res_err);
    check("idle_dut_in", int'(dut_in), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dut_in", int'(dut_in), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_fail", int'(fail_vec), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct, stuck-0 and inverted gates.
    mode = 0; full_sweep(1, 1'b0);
    mode = 1; full_sweep(1, 1'b0);
    mode = 2; full_sweep(1, 1'b0);
    // Start held high through the sweep must not restart it.
    mode = 0; full_sweep(6, 1'b0);
    // Start and abort together in IDLE: start wins.
    mode = 3; mask = NV'($urandom); full_sweep(1, 1'b1);

    // Random per-vector fault patterns, including single faults.
    for (int i = 0; i < 10; i++) begin
      mode = 3;
      mask = (i < 3) ? (NV'(1) << $urandom_range(NV - 1, 0)) : NV'($urandom);
      full_sweep(1 + (i % 3), 1'b0);
    end

    // Abort during WAIT of vector 2.
    mode = 3; mask = NV'($urandom) | NV'(3);
    issue_start(1, 1'b0, 1'b0, e0);
    while (cyc < e0 + 2 * VL + 1) @(negedge clk);
    abort = 1'b1;
    sweep_active = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_dut_in", int'(dut_in), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_err", int'(err_count), count_errs(2));
    check("abort_fail", int'(fail_vec), first_fail(2));
    repeat (TOTAL) @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    mode = 0; full_sweep(1, 1'b0);

    // Asynchronous reset during CHECK of vector 1.
    mode = 2;
    issue_start(1, 1'b0, 1'b0, e0);
    while (cyc < e0 + VL + S + 1) @(negedge clk);
    sweep_active = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dut_in", int'(dut_in), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_pass", int'(pass), 0);
    check("arst_err", int'(err_count), 0);
    check("arst_fail", int'(fail_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_dut_in", int'(dut_in), 0);
    end
    mode = 3; mask = NV'($urandom); full_sweep(1, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xor_bist_ctrl.md
Name: xor_bist_ctrl

Overview:
Built-in self-test sequencer for an N-input XOR gate. On a start pulse it drives every input combination 0 to 2^N-1 onto the gate in turn. After each vector it waits a settle interval, samples the gate output and compares it against the expected parity. It then reports pass/fail, the error count and the first failing vector. It sits between the test/config logic and the XOR gate under test.

Parameters:
N, 2, number of gate inputs (>=1)
SETTLE, 1, wait cycles between driving a vector and sampling the output (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel a sweep in progress
dut_in  output  N  vector driven to the gate under test
dut_out  input  1  gate output
busy  output  1  high in APPLY, WAIT and CHECK
done  output  1  one-cycle pulse at the end of a complete sweep
pass  output  1  sweep result; valid from done until the next start
err_count  output  N+1  number of mismatching vectors
fail_vec  output  N  first mismatching vector; valid when err_count != 0

Behaviour:
- Reset (async, rst_n=0): state IDLE, vector counter 0, settle counter 0, dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. All outputs registered.
- States:
  - IDLE: dut_in=0. On start=1, clear err_count, fail_vec and pass, set vec=0, go to APPLY. start is ignored in every other state.
  - APPLY (1 cycle): dut_in<=vec, load settle counter with SETTLE, go to WAIT.
  - WAIT (SETTLE cycles): decrement the counter each cycle; when the counter reaches 1, go to CHECK.
  - CHECK (1 cycle): expected = reduction-XOR of vec. If dut_out != expected: err_count+=1, and if err_count was 0, fail_vec<=vec. If vec == all-ones, go to DONE; else vec+=1 and go to APPLY.
  - DONE (1 cycle): done=1, pass<=(err_count==0), go to IDLE.
- dut_in is held constant from APPLY through the end of CHECK for each vector.
- dut_out is sampled only in CHECK. It is sampled on the clock edge that leaves CHECK, using the error count including the current vector.
- Timing:
  - Each vector takes SETTLE+2 cycles.
  - done is high in the cycle after edge 2^N*(SETTLE+2), counting the start-sampling edge as edge 0.
- Width rules:
  - err_count max is 2^N, which fits N+1 bits; no saturation is needed.
  - The vec counter is N bits. The end of the sweep is detected by comparison with all-ones before increment, so no wrap occurs.
- Abort:
  - abort=1 in APPLY, WAIT or CHECK: go to IDLE next edge, dut_in<=0, busy=0, no done pulse, pass=0.
  - err_count and fail_vec keep their partial values.
  - abort in IDLE or DONE has no effect.
  - abort takes priority over CHECK updates in the same cycle.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- start and abort both high in IDLE: start wins and the sweep begins.
- busy is 0 in IDLE and DONE.
- pass and err_count hold their values after DONE until the next accepted start.

Test Plan:
1. N=2, SETTLE=1, correct XOR model, start pulse -> dut_in steps 00,01,10,11, each held 3 cycles; done pulses 1 cycle, 12 edges after start; pass=1, err_count=0.
2. N=2, dut_out tied 0 -> mismatches at 01 and 10; err_count=2, fail_vec=2'b01, pass=0 at done.
3. N=2, XNOR model (inverted output) -> err_count=4, fail_vec=2'b00, pass=0.
4. N=3, SETTLE=3, correct model -> 8 vectors, each held 5 cycles; done 40 edges after start; pass=1; a second start pulse held high during busy has no effect.
5. Abort asserted during WAIT of vector 2 -> IDLE next edge, dut_in=0, busy=0, no done pulse, pass=0; a new start then runs a full clean sweep.
6. rst_n pulled low asynchronously mid-CHECK -> all outputs 0 immediately; after release the block stays IDLE until start.
